// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, default base address and SRAM bus widths
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: loadable down-counter flagging the last cycle of an SRAM phase
module sram_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic [3:0] cnt,
  output logic       tc
);
  // reload at the start of each phase, otherwise count down and stop at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  assign tc = cnt == 4'd1;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit CPU access to 16-bit async SRAM as two big-endian half-word phases
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          MEM_BYTES   = 2048,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(MEM_BYTES) - 32'd4;
  localparam logic [3:0]  WC        = 4'(WAIT_CYCLES);
  state_t state;
  logic req, in_range, wr_only, is_wr, tc, load, dec, unused_lsb;
  logic [3:0] cnt;
  logic [SRAM_AW-2:0] word_off;
  logic [SRAM_DW-1:0] lo_data;
  assign unused_lsb = ^address[1:0];
  assign req      = rd_en | wr_en;
  assign wr_only  = wr_en & ~rd_en;
  assign in_range = address[31:2] >= BASE_ADDR[31:2] && address[31:2] <= LAST_ADDR[31:2];
  assign word_off = (SRAM_AW-1)'(address[31:2] - BASE_ADDR[31:2]);
  assign ready    = (state == IDLE && !req) || state == DONE;
  assign load     = (state == IDLE && req && in_range) || (state == HI && tc);
  assign dec      = (state == HI || state == LO) && !tc;
  sram_wait_cnt u_wait (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .load_val(WC), .cnt(cnt), .tc(tc)
  );
  // access sequencer: strobe is low on every phase cycle but the last (hold) one,
  // except a single-cycle phase, which must strobe on its only cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      is_wr       <= 1'b0;
      lo_data     <= '0;
    end else
      case (state)
        IDLE:
          if (req) begin
            is_wr   <= wr_only;
            lo_data <= write_data[15:0];
            if (in_range) begin
              state       <= HI;
              sram_addr   <= {word_off, 1'b0};
              sram_dq_out <= write_data[31:16];
              sram_dq_oe  <= wr_only;
              sram_we_n   <= ~wr_only;
            end else begin
              state <= DONE;
              if (rd_en) read_data <= '0;
            end
          end
        HI:
          if (tc) begin
            if (!is_wr) read_data[31:16] <= sram_dq_in;
            state       <= LO;
            sram_addr   <= {sram_addr[SRAM_AW-1:1], 1'b1};
            sram_dq_out <= lo_data;
            sram_we_n   <= ~is_wr;
          end else sram_we_n <= ~(is_wr && cnt != 4'd2);
        LO:
          if (tc) begin
            if (!is_wr) read_data[15:0] <= sram_dq_in;
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else sram_we_n <= ~(is_wr && cnt != 4'd2);
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench with behavioural SRAMs for two wait-state settings
module tb_sram_ctrl;
  typedef struct {logic [31:0] rd; int lc, wc, oc;} exp_t;
  logic clk = 0, rst = 1, sel = 0;
  logic rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  logic [31:0] address = 0, write_data = 0;
  logic [31:0] rdat0, rdat1;
  logic rdy0, rdy1, oe0, oe1, we0, we1;
  logic [17:0] a0, a1;
  logic [15:0] dqo0, dqo1, dqi0, dqi1;
  logic [15:0] mem0 [0:63];
  logic [15:0] mem1 [0:63];
  logic m_ready, m_req, m_we_n, m_oe;
  logic [31:0] m_rd;
  exp_t q[$];
  int checks = 0, passed = 0;
  int lc = 0, wc = 0, oc = 0;

  always #5 clk = ~clk;

  sram_ctrl u0 (
    .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(address), .write_data(write_data),
    .read_data(rdat0), .ready(rdy0), .sram_addr(a0), .sram_dq_in(dqi0), .sram_dq_out(dqo0),
    .sram_dq_oe(oe0), .sram_we_n(we0)
  );
  sram_ctrl #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(address), .write_data(write_data),
    .read_data(rdat1), .ready(rdy1), .sram_addr(a1), .sram_dq_in(dqi1), .sram_dq_out(dqo1),
    .sram_dq_oe(oe1), .sram_we_n(we1)
  );

  assign dqi0 = mem0[a0[5:0]];
  assign dqi1 = mem1[a1[5:0]];
  always @(posedge clk) begin
    if (!we0 && oe0) mem0[a0[5:0]] <= dqo0;
    if (!we1 && oe1) mem1[a1[5:0]] <= dqo1;
  end

  assign m_ready = sel ? rdy1 : rdy0;
  assign m_req   = sel ? (rd1 | wr1) : (rd0 | wr0);
  assign m_we_n  = sel ? we1 : we0;
  assign m_oe    = sel ? oe1 : oe0;
  assign m_rd    = sel ? rdat1 : rdat0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk)
    if (rst) begin
      lc = 0; wc = 0; oc = 0;
    end else if (m_req) begin
      if (!m_ready) lc++;
      if (!m_we_n) wc++;
      if (m_oe) oc++;
      if (m_ready) begin
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("read_data", m_rd, e.rd);
          chk("ready_low_cycles", 32'(lc), 32'(e.lc));
          chk("we_low_cycles", 32'(wc), 32'(e.wc));
          chk("oe_cycles", 32'(oc), 32'(e.oc));
        end
        lc = 0; wc = 0; oc = 0;
      end
    end

  task automatic drive(input logic r, input logic w);
    if (sel) begin rd1 = r; wr1 = w; end
    else begin rd0 = r; wr0 = w; end
  endtask

  task automatic wait_done();
    int n = 0;
    @(posedge clk); #1;
    while (!m_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_ready) begin
      checks++;
      $display("FAIL access_timeout: ready still %b after %0d cycles, required 1", m_ready, n);
    end
    @(posedge clk); #1;
    drive(0, 0);
  endtask

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input int el, input int ew, input int eo);
    q.push_back('{erd, el, ew, eo});
    address = a;
    write_data = d;
    drive(r, w);
    wait_done();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem0[i] = 16'h0; mem1[i] = 16'h0; end
    mem0[0] = 16'hDEAD; mem0[1] = 16'hBEEF;
    mem0[4] = 16'hCAFE; mem0[5] = 16'hF00D;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_read_data", rdat0, 32'h0);
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_we_n", {31'd0, we0}, 32'd1);
    chk("rst_oe", {31'd0, oe0}, 32'd0);
    chk("rst_sram_addr", {14'd0, a0}, 32'd0);
    access(1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 5, 0, 0);
    access(0, 1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 5, 2, 4);
    chk("mem_hw2", {16'd0, mem0[2]}, 32'h1234);
    chk("mem_hw3", {16'd0, mem0[3]}, 32'h5678);
    access(1, 1, 32'd1032, 32'hFFFF0000, 32'hCAFEF00D, 5, 0, 0);
    chk("rdwr_no_write", {16'd0, mem0[4]}, 32'hCAFE);
    access(1, 0, 32'd1020, 32'h0, 32'h0, 1, 0, 0);
    chk("oor_addr_held", {14'd0, a0}, 32'd5);
    access(1, 0, 32'd1028, 32'h0, 32'h12345678, 5, 0, 0);
    access(1, 0, 32'd3072, 32'h0, 32'h0, 1, 0, 0);
    access(0, 1, 32'd3072, 32'hAAAA5555, 32'h0, 1, 0, 0);
    chk("oor_write_addr_held", {14'd0, a0}, 32'd3);
    address = 32'd1040;
    write_data = 32'hA5A55A5A;
    drive(0, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_we_n", {31'd0, we0}, 32'd1);
    chk("abort_oe", {31'd0, oe0}, 32'd0);
    chk("abort_ready", {31'd0, rdy0}, 32'd0);
    chk("abort_lo_unwritten", {16'd0, mem0[9]}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q.push_back('{32'h0, 5, 2, 4});
    wait_done();
    chk("rewrite_hw8", {16'd0, mem0[8]}, 32'hA5A5);
    chk("rewrite_hw9", {16'd0, mem0[9]}, 32'h5A5A);
    sel = 1;
    access(0, 1, 32'd1048, 32'h87654321, 32'h0, 3, 2, 2);
    chk("w1_hw12", {16'd0, mem1[12]}, 32'h8765);
    chk("w1_hw13", {16'd0, mem1[13]}, 32'h4321);
    access(1, 0, 32'd1048, 32'h0, 32'h87654321, 3, 0, 0);
    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024, meaning the CPU byte address that maps to SRAM half-word 0.
REQ-002 SHALL have parameter MEM_BYTES, default 2048, meaning the size of the mapped window in bytes.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2 (legal range 1..15), meaning the number of SRAM cycles per half-word phase.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port rd_en, input, 1 bit: read request from the pipeline MEM stage.
REQ-008 SHALL have port wr_en, input, 1 bit: write request from the pipeline MEM stage.
REQ-009 SHALL have port address, input, 32 bits: CPU byte address.
REQ-010 SHALL have port write_data, input, 32 bits: store data.
REQ-011 SHALL have port read_data, output, 32 bits: load data.
REQ-012 SHALL have port ready, output, 1 bit: 0 freezes the pipeline.
REQ-013 SHALL have port sram_addr, output, 18 bits: SRAM half-word address.
REQ-014 SHALL have port sram_dq_in, input, 16 bits: SRAM read bus.
REQ-015 SHALL have port sram_dq_out, output, 16 bits: SRAM write bus.
REQ-016 SHALL have port sram_dq_oe, output, 1 bit: 1 means the controller drives the data bus.
REQ-017 SHALL have port sram_we_n, output, 1 bit: active-low SRAM write strobe.

Function
REQ-018 SHALL implement the FSM states IDLE, HI, LO and DONE.
REQ-019 IDLE: rd_en|wr_en and address in range SHALL go to HI; a request with address out of range SHALL go to DONE; no request SHALL stay in IDLE.
REQ-020 HI and LO SHALL each last exactly WAIT_CYCLES cycles, counted by a 4-bit wait counter; HI SHALL go to LO, LO SHALL go to DONE, and DONE SHALL go to IDLE unconditionally.
REQ-021 ready SHALL be combinational: 1 in IDLE with no request, 1 in DONE, 0 otherwise.
REQ-022 An in-range access SHALL have ready low for 2*WAIT_CYCLES+1 cycles, then high for 1 cycle in DONE.
REQ-023 The pipeline SHALL hold rd_en, wr_en, address and write_data stable while ready=0; the controller SHALL latch all four on leaving IDLE.
REQ-024 In range SHALL mean BASE_ADDR <= address <= BASE_ADDR+MEM_BYTES-4; address[1:0] SHALL be ignored.
REQ-025 Half-word base SHALL be ((address-BASE_ADDR)>>1) with bit 0 cleared; HI SHALL use base and LO SHALL use base+1.
REQ-026 The layout SHALL be big-endian: HI carries bits [31:16] and LO carries bits [15:0].
REQ-027 When both rd_en and wr_en are set, the read SHALL win and no write SHALL occur.
REQ-028 Read: sram_dq_oe=0 and sram_we_n=1 throughout; sram_dq_in SHALL be captured on the last cycle of HI into read_data[31:16] and on the last cycle of LO into read_data[15:0].
REQ-029 Write: sram_dq_oe=1 throughout HI/LO; sram_we_n=0 on all HI/LO cycles except the last cycle of each phase (data-hold cycle); sram_dq_out SHALL carry the phase half-word.
REQ-030 read_data SHALL hold its value until the next read's capture; writes SHALL NOT alter read_data.
REQ-031 An out-of-range read SHALL set read_data=0 in DONE; an out-of-range write SHALL issue no SRAM cycle.
REQ-032 Outside HI/LO, sram_we_n=1, sram_dq_oe=0 and sram_addr SHALL hold its last value.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE, wait counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0 and sram_we_n=1.
REQ-034 Reset mid-access SHALL abort the access with no further strobe; after release, a held request SHALL restart from HI.

Structure
REQ-035 A shared package SHALL hold the state enum, the default BASE_ADDR and the SRAM address and data widths.
REQ-036 The wait counter SHALL be the sub-module sram_wait_cnt (load, decrement, terminal-count flag); everything else SHALL be inline.

Verification
REQ-037 Read: SRAM half-words 0x0000=16'hDEAD and 0x0001=16'hBEEF, rd_en with address=1024 -> ready low 5 cycles, then read_data=32'hDEADBEEF with ready=1.
REQ-038 Write: wr_en, address=1028, write_data=32'h12345678 -> half-word 0x0002 receives 16'h1234 and 0x0003 receives 16'h5678; sram_we_n low for 1 cycle per phase.
REQ-039 rd_en=wr_en=1 at address 1032 -> read occurs, sram_we_n stays 1.
REQ-040 Out of range: rd_en at address=1020 and at address=3072 -> ready=1 on the next cycle, read_data=0, no SRAM activity.
REQ-041 Reset during LO of a write -> sram_we_n=1 immediately and state=IDLE; after release, the write re-executes fully.
REQ-042 Back-to-back: write then read of the same address with WAIT_CYCLES=1 -> readback equals written data, each access has ready low for 3 cycles.
